// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mem_access_unit                                                 |
// | Brief  : MEM-stage load/store unit. Turns EX/MEM load/store controls     |
// |          into byte-enabled requests on a variable-latency data bus,      |
// |          aligns and extends returned load data, and stalls the pipeline  |
// |          until each access completes or times out.                       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  Funct3_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData_M,
  output logic        Stall_M,
  output logic        Fault_M,
  output logic        Bus_Err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          w_access;
  logic          w_f3_legal;
  logic          w_misalign;
  logic          w_fault;
  logic          w_start;
  logic          w_busy;
  logic          w_timeout;
  logic [3:0]    w_be_req;
  logic [31:0]   w_wdata_req;
  logic [31:0]   w_lane;
  logic [31:0]   w_load_ext;

  assign w_access = MemRead_M | MemWrite_M;
  assign w_busy   = (state_q == REQ) || (state_q == WAIT_R);
  // The last budgeted cycle aborts instead of requesting, so REQ+WAIT_R never exceeds TIMEOUT cycles.
  assign w_timeout = w_busy && (cnt_q == CW'(TIMEOUT - 1));

  // Decode legality and natural alignment of the access presented in IDLE.
  always_comb begin
    w_f3_legal = (Funct3_M == 3'b000) || (Funct3_M == 3'b001) || (Funct3_M == 3'b010) ||
                 (Funct3_M == 3'b100) || (Funct3_M == 3'b101);
    w_misalign = ((Funct3_M[1:0] == 2'b01) && ALUResult_M[0]) ||
                 ((Funct3_M[1:0] == 2'b10) && (ALUResult_M[1:0] != 2'b00));
  end

  assign w_fault = (state_q == IDLE) && w_access && (!w_f3_legal || w_misalign);
  assign w_start = (state_q == IDLE) && w_access && w_f3_legal && !w_misalign;

  // Build byte enables and lane-replicated store data; loads always fetch the whole word.
  always_comb begin
    w_be_req    = 4'b1111;
    w_wdata_req = WriteData_M;
    if (MemWrite_M) begin
      case (Funct3_M[1:0])
        2'b00: begin
          w_be_req    = 4'b0001 << ALUResult_M[1:0];
          w_wdata_req = {4{WriteData_M[7:0]}};
        end
        2'b01: begin
          w_be_req    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
          w_wdata_req = {2{WriteData_M[15:0]}};
        end
        default: begin
          w_be_req    = 4'b1111;
          w_wdata_req = WriteData_M;
        end
      endcase
    end
  end

  // Shift the addressed lane down to bit 0 and sign/zero extend by access size.
  always_comb begin
    w_lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load_ext = {24'd0, w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load_ext = {16'd0, w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // Next-state logic: one request per access, RESP always returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (w_fault) begin
          rdata_d = '0;
        end else if (w_start) begin
          state_d = REQ;
          addr_d  = {ALUResult_M[31:2], 2'b00};
          we_d    = MemWrite_M;
          be_d    = w_be_req;
          wdata_d = w_wdata_req;
          f3_d    = Funct3_M;
          off_d   = ALUResult_M[1:0];
          rdata_d = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (w_timeout) begin
          state_d = RESP;
          cnt_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (mem_gnt) begin
          state_d = we_q ? RESP : WAIT_R;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + CW'(1);
        if (w_timeout) begin
          state_d = RESP;
          cnt_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (mem_rvalid) begin
          state_d = RESP;
          rdata_d = w_load_ext;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset returns to IDLE with no sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req    = (state_q == REQ) && !w_timeout;
  assign mem_we     = (state_q == REQ) && we_q;
  assign mem_be     = (state_q == REQ) ? be_q : 4'b0000;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  // Gated by rst so the pipeline is released the instant reset asserts.
  assign Stall_M    = rst && (w_start || w_busy);
  assign Fault_M    = w_fault;
  assign ReadData_M = w_fault ? 32'd0 : rdata_q;
  assign Bus_Err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_mem_access_unit                                              |
// | Brief  : Self-checking bench for mem_access_unit with a bus responder    |
// |          and an arithmetic reference model of the load/store rules.      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;
  localparam int TIMEOUT = 64;
  localparam int BOUND   = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead_M = 1'b0, MemWrite_M = 1'b0;
  logic [2:0]  Funct3_M = 3'b000;
  logic [31:0] ALUResult_M = 32'd0, WriteData_M = 32'd0;
  logic [31:0] ReadData_M;
  logic        Stall_M, Fault_M, Bus_Err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int errors = 0;
  int checks = 0;
  logic model_err = 1'b0;

  // observations from the last run_access call
  int          obs_stall, obs_req;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic        obs_we, obs_stable, obs_fault, obs_err;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .Funct3_M(Funct3_M),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
    .ReadData_M(ReadData_M), .Stall_M(Stall_M), .Fault_M(Fault_M), .Bus_Err(Bus_Err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_fault(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    return (int'(a[1:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int mask;
    if (!wr) return 4'hF;
    mask = ((1 << m_size(f3)) - 1) << int'(a[1:0]);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (m_size(f3) == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (m_size(f3) == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v, mask;
    int bits;
    v = word >> (8 * int'(a[1:0]));
    bits = 8 * m_size(f3);
    if (bits == 32) return v;
    mask = (32'd1 << bits) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // cycles the access spends in REQ+WAIT_R if the bus answers in time
  function automatic int m_done(input logic wr, input int gd, input int rvd);
    return gd + 1 + (wr ? 0 : rvd);
  endfunction

  function automatic logic m_tmo(input logic wr, input int gd, input int rvd);
    return m_done(wr, gd, rvd) > TIMEOUT - 1;
  endfunction

  function automatic int m_stall(input logic wr, input int gd, input int rvd);
    return 1 + (m_tmo(wr, gd, rvd) ? TIMEOUT : m_done(wr, gd, rvd));
  endfunction

  function automatic int m_req(input logic wr, input int gd, input int rvd);
    if (!m_tmo(wr, gd, rvd)) return gd + 1;
    return (gd + 1 < TIMEOUT - 1) ? gd + 1 : TIMEOUT - 1;
  endfunction

  // ---------------- driver / bus responder ----------------
  // Entered just after a falling edge; presents one access and plays the bus
  // until the stall drops, then withdraws the access one cycle later.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int gd, input int rvd, input logic [31:0] word,
                            input logic junk_rv);
    int cyc;
    int gnt_cyc;
    logic first;
    MemRead_M = rd; MemWrite_M = wr; Funct3_M = f3; ALUResult_M = a; WriteData_M = wd;
    obs_stall = 0; obs_req = 0; obs_be = '0; obs_addr = '0; obs_wdata = '0; obs_we = 1'b0;
    obs_stable = 1'b1; obs_rdata = '0; obs_fault = 1'b0; obs_err = 1'b0;
    gnt_cyc = -1; first = 1'b1;
    for (cyc = 0; cyc < BOUND; cyc++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      #1;
      if (cyc == 0) obs_fault = Fault_M;
      if (mem_req) begin
        obs_req++;
        if (first) begin
          obs_be = mem_be; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we; first = 1'b0;
        end else if (mem_be !== obs_be || mem_addr !== obs_addr || mem_wdata !== obs_wdata || mem_we !== obs_we) begin
          obs_stable = 1'b0;
        end
        if (obs_req == gd + 1) begin
          mem_gnt = 1'b1; gnt_cyc = cyc;
          if (junk_rv) begin mem_rvalid = 1'b1; mem_rdata = ~word; end
        end
      end else if (!wr && gnt_cyc >= 0 && cyc - gnt_cyc == rvd) begin
        mem_rvalid = 1'b1; mem_rdata = word;
      end
      if (!Stall_M) begin
        obs_rdata = ReadData_M; obs_err = Bus_Err;
        break;
      end
      obs_stall++;
      @(negedge clk);
    end
    checks++;
    if (cyc >= BOUND) begin errors++; $display("FAIL access_bound: stall still high after %0d cycles, required release", cyc); end
    @(negedge clk);
    MemRead_M = 1'b0; MemWrite_M = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (Stall_M !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b required 0", Stall_M); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b required 0", mem_we); end
    checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL rst_be: got %h required 0", mem_be); end
    checks++; if (Bus_Err !== 1'b0) begin errors++; $display("FAIL rst_buserr: got %b required 0", Bus_Err); end
    checks++; if (ReadData_M !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h required 0", ReadData_M); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    run_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1, 32'd0, 1'b0);
    checks++; if (obs_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b required 1111", obs_be); end
    checks++; if (obs_addr !== 32'h10) begin errors++; $display("FAIL sw_addr: got %h required 00000010", obs_addr); end
    checks++; if (obs_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h required deadbeef", obs_wdata); end
    checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b required 1", obs_we); end
    checks++; if (obs_req !== 1) begin errors++; $display("FAIL sw_reqs: got %0d required 1", obs_req); end
    checks++; if (obs_stall !== m_stall(1'b1, 0, 1)) begin errors++; $display("FAIL sw_stall: got %0d required %0d", obs_stall, m_stall(1'b1, 0, 1)); end
    checks++; if (obs_rdata !== 32'd0) begin errors++; $display("FAIL sw_rdata: got %h required 0", obs_rdata); end
  endtask

  task automatic test_load_byte();
    // rvalid also pulsed with wrong data in the grant cycle; it must be ignored
    run_access(1'b1, 1'b0, 3'b000, 32'h13, 32'd0, 0, 2, 32'h80FF_0000, 1'b1);
    checks++; if (obs_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h required ffffff80", obs_rdata); end
    checks++; if (obs_be !== 4'b1111 || obs_addr !== 32'h10 || obs_we !== 1'b0) begin errors++;
      $display("FAIL lb_bus: got be=%b addr=%h we=%b required be=1111 addr=00000010 we=0", obs_be, obs_addr, obs_we); end
    checks++; if (obs_stall !== m_stall(1'b0, 0, 2)) begin errors++; $display("FAIL lb_stall: got %0d required %0d", obs_stall, m_stall(1'b0, 0, 2)); end
    run_access(1'b1, 1'b0, 3'b100, 32'h13, 32'd0, 0, 2, 32'h80FF_0000, 1'b1);
    checks++; if (obs_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h required 00000080", obs_rdata); end
  endtask

  task automatic test_halfword();
    run_access(1'b0, 1'b1, 3'b001, 32'h06, 32'h0000ABCD, 1, 1, 32'd0, 1'b0);
    checks++; if (obs_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b required 1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h required abcdabcd", obs_wdata); end
    checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL sh_stable: got %b required 1", obs_stable); end
    run_access(1'b1, 1'b0, 3'b010, 32'h08, 32'd0, 0, 1, 32'h12345678, 1'b0);
    checks++; if (obs_rdata !== 32'h12345678) begin errors++; $display("FAIL lw_rdata: got %h required 12345678", obs_rdata); end
    run_access(1'b1, 1'b0, 3'b001, 32'h05, 32'd0, 0, 1, 32'hFFFFFFFF, 1'b0);
    checks++; if (obs_fault !== 1'b1) begin errors++; $display("FAIL lh_fault: got %b required 1", obs_fault); end
    checks++; if (obs_req !== 0) begin errors++; $display("FAIL lh_noreq: got %0d requests required 0", obs_req); end
    checks++; if (obs_stall !== 0) begin errors++; $display("FAIL lh_nostall: got %0d stall cycles required 0", obs_stall); end
    checks++; if (obs_rdata !== 32'd0) begin errors++; $display("FAIL lh_rdata: got %h required 0", obs_rdata); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 0, 1, 32'hCAFEF00D, 1'b0);
    checks++; if (obs_req !== 1) begin errors++; $display("FAIL b2b_lw_reqs: got %0d required 1", obs_req); end
    checks++; if (obs_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_lw_rdata: got %h required cafef00d", obs_rdata); end
    run_access(1'b0, 1'b1, 3'b010, 32'h44, 32'h0BADBEEF, 0, 1, 32'd0, 1'b0);
    checks++; if (obs_req !== 1) begin errors++; $display("FAIL b2b_sw_reqs: got %0d required 1", obs_req); end
    checks++; if (obs_addr !== 32'h44 || obs_wdata !== 32'h0BADBEEF) begin errors++;
      $display("FAIL b2b_sw_bus: got addr=%h wdata=%h required 00000044 0badbeef", obs_addr, obs_wdata); end
    #1;
    checks++; if (mem_req !== 1'b0 || Stall_M !== 1'b0) begin errors++;
      $display("FAIL b2b_idle: got req=%b stall=%b required 0 0", mem_req, Stall_M); end
  endtask

  task automatic test_random();
    logic rd, wr, junk, flt;
    logic [2:0] f3;
    logic [31:0] a, wd, word, e_rd;
    int gd, rvd;
    logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      f3 = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 2)] : legal[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'(m_size(f3) * $urandom_range(0, 3));
      wd = $urandom; word = $urandom;
      gd = $urandom_range(0, 3); rvd = $urandom_range(1, 3); junk = 1'($urandom_range(0, 1));
      flt = m_fault(f3, a);
      run_access(rd, wr, f3, a, wd, gd, rvd, word, junk);
      if (!flt && m_tmo(wr, gd, rvd)) model_err = 1'b1;
      e_rd = (flt || wr || m_tmo(wr, gd, rvd)) ? 32'd0 : m_load(f3, a, word);
      checks++; if (obs_fault !== flt) begin errors++; $display("FAIL rnd%0d_fault: got %b required %b", i, obs_fault, flt); end
      checks++; if (obs_stall !== (flt ? 0 : m_stall(wr, gd, rvd))) begin errors++;
        $display("FAIL rnd%0d_stall: got %0d required %0d", i, obs_stall, flt ? 0 : m_stall(wr, gd, rvd)); end
      checks++; if (obs_req !== (flt ? 0 : m_req(wr, gd, rvd))) begin errors++;
        $display("FAIL rnd%0d_reqs: got %0d required %0d", i, obs_req, flt ? 0 : m_req(wr, gd, rvd)); end
      checks++; if (obs_rdata !== e_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h required %h", i, obs_rdata, e_rd); end
      checks++; if (obs_err !== model_err) begin errors++; $display("FAIL rnd%0d_buserr: got %b required %b", i, obs_err, model_err); end
      if (!flt) begin
        checks++; if (obs_addr !== {a[31:2], 2'b00} || obs_be !== m_be(wr, f3, a) || obs_we !== wr || obs_stable !== 1'b1) begin errors++;
          $display("FAIL rnd%0d_bus: got addr=%h be=%b we=%b stable=%b required addr=%h be=%b we=%b stable=1",
                   i, obs_addr, obs_be, obs_we, obs_stable, {a[31:2], 2'b00}, m_be(wr, f3, a), wr); end
        if (wr) begin
          checks++; if (obs_wdata !== m_wdata(f3, wd)) begin errors++;
            $display("FAIL rnd%0d_wdata: got %h required %h", i, obs_wdata, m_wdata(f3, wd)); end
        end
      end
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 100000, 1, 32'h5555AAAA, 1'b0);
    model_err = 1'b1;
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL tmo_buserr: got %b required 1", obs_err); end
    checks++; if (obs_rdata !== 32'd0) begin errors++; $display("FAIL tmo_rdata: got %h required 0", obs_rdata); end
    checks++; if (obs_stall !== m_stall(1'b0, 100000, 1)) begin errors++;
      $display("FAIL tmo_stall: got %0d required %0d", obs_stall, m_stall(1'b0, 100000, 1)); end
    checks++; if (obs_req !== m_req(1'b0, 100000, 1)) begin errors++;
      $display("FAIL tmo_reqs: got %0d required %0d", obs_req, m_req(1'b0, 100000, 1)); end
    run_access(1'b0, 1'b1, 3'b000, 32'h21, 32'h000000A5, 0, 1, 32'd0, 1'b0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", obs_err); end
    checks++; if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL tmo_sb_bus: got be=%b wdata=%h required 0010 a5a5a5a5", obs_be, obs_wdata); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    MemRead_M = 1'b1; MemWrite_M = 1'b0; Funct3_M = 3'b010; ALUResult_M = 32'h44;
    @(negedge clk);
    #1; ok = mem_req; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    checks++; if (ok !== 1'b1 || Stall_M !== 1'b1 || mem_req !== 1'b0) begin errors++;
      $display("FAIL rmid_waitr: got req_then=%b stall=%b req=%b required 1 1 0", ok, Stall_M, mem_req); end
    #1; rst = 1'b0; #1;
    model_err = 1'b0;
    checks++; if (mem_req !== 1'b0 || Stall_M !== 1'b0 || mem_be !== 4'h0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL rmid_drop: got req=%b stall=%b be=%b we=%b required all 0", mem_req, Stall_M, mem_be, mem_we); end
    checks++; if (Bus_Err !== 1'b0) begin errors++; $display("FAIL rmid_buserr: got %b required 0", Bus_Err); end
    MemRead_M = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_access(1'b1, 1'b0, 3'b010, 32'h48, 32'd0, 1, 1, 32'h0F1E2D3C, 1'b0);
    checks++; if (obs_rdata !== 32'h0F1E2D3C) begin errors++; $display("FAIL rmid_lw_rdata: got %h required 0f1e2d3c", obs_rdata); end
    checks++; if (obs_req !== 2 || obs_stall !== m_stall(1'b0, 1, 1)) begin errors++;
      $display("FAIL rmid_lw_timing: got reqs=%0d stall=%0d required 2 %0d", obs_req, obs_stall, m_stall(1'b0, 1, 1)); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL rmid_lw_err: got %b required 0", obs_err); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_halfword();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
